// File: rtl/ball_game.sv
// ball_game: single-player pong; game state advances once per frame, pixel colour is registered.
module ball_game #(
    parameter int HACTIVE   = 640,
    parameter int VACTIVE   = 480,
    parameter int BALL      = 8,
    parameter int PAD_X     = 16,
    parameter int PAD_W     = 8,
    parameter int PAD_H     = 64,
    parameter int BSTEP     = 2,
    parameter int PSTEP     = 4,
    parameter int MISS_HOLD = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [9:0]  ypos,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_serve,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic [3:0]  miss_count
);
    localparam logic [1:0] SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2;
    localparam logic signed [10:0] SX    = 11'(BSTEP);
    localparam logic signed [9:0]  SY    = 10'(BSTEP);
    localparam logic signed [10:0] X_MAX = 11'(HACTIVE - BALL);
    localparam logic signed [9:0]  Y_MAX = 10'(VACTIVE - BALL);
    localparam logic signed [10:0] PAD_R = 11'(PAD_X + PAD_W);
    localparam int PY_MAX = VACTIVE - PAD_H;
    localparam logic [9:0] BX0 = 10'((HACTIVE - BALL) / 2);
    localparam logic [8:0] BY0 = 9'((VACTIVE - BALL) / 2);
    localparam logic [8:0] PY0 = 9'((VACTIVE - PAD_H) / 2);
    logic [1:0]  state;
    logic [9:0]  prev_y, bx, bx_n;
    logic [8:0]  by, by_n, py, py_n;
    logic [5:0]  miss_cnt;
    logic        dx, dy, dx_n, dy_n, frame_tick;
    logic        x_wall, y_hi, y_lo, hit, miss;
    logic        in_vis, in_ball, in_pad, on_edge;
    logic [7:0]  pix;
    logic signed [10:0] nx;
    logic signed [9:0]  ny;
    // dx/dy set means moving toward smaller coordinates
    assign nx = $signed({1'b0, bx}) + (dx ? -SX : SX);
    assign ny = $signed({1'b0, by}) + (dy ? -SY : SY);
    always_comb begin
        x_wall = nx >= X_MAX;
        y_hi   = ny >= Y_MAX;
        y_lo   = ny <= 10'sd0;
        by_n   = y_hi ? 9'(Y_MAX) : y_lo ? 9'd0 : ny[8:0];
        hit    = dx && nx <= PAD_R && bx > 10'(PAD_R)
                 && {1'b0, by_n} < {1'b0, py} + 10'(PAD_H)
                 && {1'b0, by_n} + 10'(BALL) > {1'b0, py};
        miss   = dx && nx <= 11'sd0 && !hit;
        bx_n   = x_wall ? 10'(X_MAX) : hit ? 10'(PAD_R + 1) : miss ? 10'd0 : nx[9:0];
        dx_n   = x_wall ? 1'b1 : hit ? 1'b0 : dx;
        dy_n   = y_hi ? 1'b1 : y_lo ? 1'b0 : dy;
        py_n   = (btn_up && !btn_down) ? (py < 9'(PSTEP) ? 9'd0 : py - 9'(PSTEP))
               : (btn_down && !btn_up) ? (py > 9'(PY_MAX - PSTEP) ? 9'(PY_MAX) : py + 9'(PSTEP))
               : py;
    end
    always_comb begin
        in_vis  = xpos < 12'(HACTIVE) && ypos < 10'(VACTIVE);
        in_ball = xpos >= {2'b0, bx} && xpos < {2'b0, bx} + 12'(BALL)
                  && ypos >= {1'b0, by} && ypos < {1'b0, by} + 10'(BALL);
        in_pad  = xpos >= 12'(PAD_X) && xpos < 12'(PAD_X + PAD_W)
                  && ypos >= {1'b0, py} && ypos < {1'b0, py} + 10'(PAD_H);
        on_edge = xpos == 12'd0 || xpos == 12'(HACTIVE - 1) || ypos == 10'd0 || ypos == 10'(VACTIVE - 1);
        pix     = !in_vis ? 8'h00 : in_ball ? 8'hFF : in_pad ? 8'h1C : on_edge ? 8'h6D
                : state == MISS ? 8'h80 : 8'h01;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SERVE;
            bx         <= BX0;
            by         <= BY0;
            dx         <= 1'b0;
            dy         <= 1'b0;
            py         <= PY0;
            miss_count <= 4'd0;
            miss_cnt   <= 6'd0;
            prev_y     <= 10'd0;
            frame_tick <= 1'b0;
            {red, green, blue} <= 8'h00;
        end else begin
            prev_y     <= ypos;
            frame_tick <= ypos == 10'(VACTIVE) && prev_y != 10'(VACTIVE);
            {red, green, blue} <= pix;
            if (frame_tick) begin
                py <= py_n;
                if (state == SERVE) begin
                    state <= btn_serve ? PLAY : SERVE;
                end else if (state == PLAY) begin
                    bx <= bx_n;
                    by <= by_n;
                    dx <= dx_n;
                    dy <= dy_n;
                    if (miss) begin
                        state      <= MISS;
                        miss_cnt   <= 6'd0;
                        miss_count <= miss_count + 4'(miss_count != 4'hF);
                    end
                end else if (miss_cnt == 6'(MISS_HOLD - 1)) begin
                    state    <= SERVE;
                    miss_cnt <= 6'd0;
                    bx       <= BX0;
                    by       <= BY0;
                    dx       <= 1'b0;
                    dy       <= 1'b0;
                end else begin
                    miss_cnt <= miss_cnt + 6'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ball_game.sv
// tb_ball_game: randomized pixel probes scored against a frame-level game model.
module tb_ball_game;
    logic        clk = 0, rst = 0;
    logic [11:0] xpos = 0;
    logic [9:0]  ypos = 0;
    logic        btn_up = 0, btn_down = 0, btn_serve = 0;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic [3:0]  miss_count;

    ball_game dut (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .btn_up(btn_up), .btn_down(btn_down), .btn_serve(btn_serve),
        .red(red), .green(green), .blue(blue), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] rgb;
        logic [3:0] mc;
        int         x;
        int         y;
    } exp_t;

    exp_t q[$];
    int cyc = 0, checks = 0, errors = 0, misses = 0;
    int m_bx, m_by, m_dx, m_dy, m_py, m_st, m_mc, m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.due != cyc || {red, green, blue} != e.rgb || miss_count != e.mc) begin
                errors++;
                $display("FAIL pixel(%0d,%0d) cyc %0d: got rgb=%h miss=%0d, expected rgb=%h miss=%0d",
                         e.x, e.y, cyc, {red, green, blue}, miss_count, e.rgb, e.mc);
            end
        end
    end

    function automatic void model_reset();
        m_st = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1; m_py = 208; m_mc = 0; m_cnt = 0;
    endfunction

    function automatic void model_tick(bit u, bit d, bit s);
        int nx, ny;
        bit hit;
        if (m_st == 0) begin
            if (s) m_st = 1;
        end else if (m_st == 1) begin
            nx = m_bx + 2 * m_dx;
            ny = m_by + 2 * m_dy;
            if (ny + 8 >= 480) begin ny = 472; m_dy = -1; end
            else if (ny <= 0) begin ny = 0; m_dy = 1; end
            hit = m_dx < 0 && nx <= 24 && m_bx > 24 && ny < m_py + 64 && ny + 8 > m_py;
            if (nx + 8 >= 640) begin nx = 632; m_dx = -1; end
            else if (hit) begin nx = 25; m_dx = 1; end
            else if (nx <= 0) begin
                nx = 0; m_st = 2; m_cnt = 0; misses++;
                if (m_mc < 15) m_mc++;
            end
            m_bx = nx;
            m_by = ny;
        end else begin
            m_cnt++;
            if (m_cnt == 60) begin
                m_st = 0; m_cnt = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
            end
        end
        if (u && !d) m_py = (m_py - 4 < 0) ? 0 : m_py - 4;
        else if (d && !u) m_py = (m_py + 4 > 416) ? 416 : m_py + 4;
    endfunction

    function automatic logic [7:0] colour(int x, int y);
        if (x >= 640 || y >= 480) return 8'h00;
        if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return {3'd7, 3'd7, 2'd3};
        if (x >= 16 && x < 24 && y >= m_py && y < m_py + 64) return {3'd0, 3'd7, 2'd0};
        if (x == 0 || x == 639 || y == 0 || y == 479) return {3'd3, 3'd3, 2'd1};
        return m_st == 2 ? {3'd4, 3'd0, 2'd0} : {3'd0, 3'd0, 2'd1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe_at(input int x, input int y);
        exp_t e;
        xpos = 12'(x);
        ypos = 10'(y);
        e.due = cyc + 1; e.rgb = colour(x, y); e.mc = 4'(m_mc); e.x = x; e.y = y;
        q.push_back(e);
        step();
    endtask

    task automatic probe_rand();
        int k, x, y;
        k = $urandom_range(0, 7);
        case (k)
            0: begin x = m_bx + $urandom_range(0, 7); y = m_by + $urandom_range(0, 7); end
            1: begin x = m_bx + 8; y = m_by; end
            2: begin x = m_bx + $urandom_range(0, 7); y = (m_by == 0) ? 8 : m_by - 1; end
            3: begin x = 16 + $urandom_range(0, 7); y = m_py + $urandom_range(0, 63); end
            4: begin x = 16 + $urandom_range(0, 7); y = (m_py > 0) ? m_py - 1 : m_py + 64; end
            5: case ($urandom_range(0, 3))
                   0: begin x = 0; y = $urandom_range(0, 479); end
                   1: begin x = 639; y = $urandom_range(0, 479); end
                   2: begin x = $urandom_range(0, 639); y = 0; end
                   default: begin x = $urandom_range(0, 639); y = 479; end
               endcase
            6: begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
            default: if ($urandom_range(0, 1) == 1) begin x = $urandom_range(640, 799); y = $urandom_range(0, 479); end
                     else begin x = $urandom_range(0, 799); y = $urandom_range(481, 520); end
        endcase
        probe_at(x, y);
    endtask

    task automatic frame(input bit u, input bit d, input bit s);
        btn_up = u; btn_down = d; btn_serve = s;
        ypos = 10'd480;
        step();
        step();
        model_tick(u, d, s);
        probe_rand();
    endtask

    task automatic do_reset();
        exp_t e;
        rst = 1;
        e.due = cyc + 1; e.rgb = 8'h00; e.mc = 4'd0; e.x = xpos; e.y = ypos;
        q.push_back(e);
        step();
        rst = 0;
        model_reset();
    endtask

    initial begin
        int n;
        bit u, d;
        ypos = 10'd100;
        step();
        do_reset();
        probe_at(320, 240);
        frame(0, 0, 0);
        probe_at(320, 240);
        probe_at(700, 100);
        probe_at(316, 236);
        probe_at(324, 236);
        for (int i = 0; i < 3; i++) frame(0, 0, 0);
        frame(0, 0, 1);
        for (int i = 0; i < 8; i++) frame(0, 0, 0);
        probe_at(332, 252);
        probe_at(331, 252);
        probe_at(339, 259);
        for (int i = 0; i < 110; i++) frame(0, 1, 1);
        probe_at(16, 479);
        probe_at(23, 416);
        probe_at(16, 415);
        for (int i = 0; i < 5; i++) frame(1, 1, 1);
        probe_at(16, 416);
        for (int i = 0; i < 110; i++) frame(1, 0, 1);
        probe_at(20, 0);
        probe_at(20, 64);
        // paddle chases the ball to produce bounces off the paddle
        for (int i = 0; i < 1000; i++) begin
            u = m_py + 32 > m_by + 6;
            d = m_py + 32 < m_by + 2;
            frame(u, d, 1);
        end
        // paddle runs away from the ball to rack up misses past saturation
        n = 0;
        while (misses < 17 && n < 12000) begin
            frame(m_by >= 236, m_by < 236, 1);
            n++;
        end
        n = 0;
        while (m_st != 2 && n < 2000) begin
            frame(m_by >= 236, m_by < 236, 1);
            n++;
        end
        checks++;
        if (m_mc != 15 || m_st != 2) begin
            errors++;
            $display("FAIL miss_setup: model miss=%0d state=%0d, needed miss=15 in MISS", m_mc, m_st);
        end
        for (int i = 0; i < 10; i++) frame(0, 0, 1);
        probe_at(300, 200);
        do_reset();
        probe_at(320, 240);
        probe_at(300, 200);
        for (int i = 0; i < 4; i++) frame(0, 0, 0);
        probe_at(316, 236);
        repeat (3) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ball_game.md
BALL_GAME -- requirements
Module: ball_game

Interface
REQ-001 Parameters SHALL be: HACTIVE 640 (visible width, pixels); VACTIVE 480 (visible height, lines); BALL 8 (ball side, pixels); PAD_X 16 (paddle left column); PAD_W 8 (paddle width); PAD_H 64 (paddle height); BSTEP 2 (ball pixels/frame per axis); PSTEP 4 (paddle pixels/frame); MISS_HOLD 60 (frames spent in MISS).
REQ-002 Port: clk, input, 1, system clock (100 MHz; the pixel position advances every 4 clocks).
REQ-003 Port: rst, input, 1, synchronous active-high reset.
REQ-004 Port: xpos, input, 12, current pixel column from the VGA sync stage (0..799).
REQ-005 Port: ypos, input, 10, current line from the VGA sync stage (0..520).
REQ-006 Port: btn_up / btn_down / btn_serve, input, 1 each, player buttons, already synchronised, level-sensitive.
REQ-007 Port: red, output, 3; green, output, 3; blue, output, 2; pixel colour to the VGA sync stage.
REQ-008 Port: miss_count, output, 4, number of missed balls, saturating.
REQ-009 Ports SHALL be one clock (clk) and a synchronous active-high reset (rst); no other clock or async input.

Function
REQ-010 frame_tick SHALL be a 1-clk pulse in the clock after ypos changes to VACTIVE from any other value (registered previous ypos); all game state updates only on frame_tick.
REQ-011 State machine SHALL have states SERVE, PLAY, MISS.
REQ-012 SERVE: ball held at (316,236), dx=+1, dy=+1; on frame_tick with btn_serve=1 -> PLAY.
REQ-013 PLAY, per frame_tick, x axis: bx += BSTEP*dx; if result + BALL >= HACTIVE then bx = HACTIVE-BALL and dx = -1.
REQ-014 PLAY, y axis: by += BSTEP*dy; if result + BALL >= VACTIVE then by = VACTIVE-BALL and dy = -1; if result <= 0 (signed compare, no unsigned wrap) then by = 0 and dy = +1.
REQ-015 PLAY paddle hit: moving left, new bx <= PAD_X+PAD_W, old bx > PAD_X+PAD_W, and [by, by+BALL) overlaps [py, py+PAD_H) -> bx = PAD_X+PAD_W+1, dx = +1.
REQ-016 PLAY miss: new bx <= 0 without a paddle hit -> bx = 0; miss_count += 1, saturating at 15; -> MISS.
REQ-017 MISS: a 6-bit frame counter counts frame_ticks; after MISS_HOLD ticks -> SERVE and the counter clears.
REQ-018 Paddle, every state, per frame_tick: btn_up only -> py -= PSTEP, clamped at 0; btn_down only -> py += PSTEP, clamped at VACTIVE-PAD_H (416); both or neither -> no move.
REQ-019 Render (combinational), priority order:
- xpos >= HACTIVE or ypos >= VACTIVE -> 0/0/0.
- Ball box (bx <= xpos < bx+BALL, by <= ypos < by+BALL) -> 7/7/3.
- Paddle box -> 0/7/0.
- Border (xpos == 0, xpos == HACTIVE-1, ypos == 0 or ypos == VACTIVE-1) -> 3/3/1.
- In MISS state, background -> 4/0/0.
- Else background -> 0/0/1.
REQ-020 red/green/blue SHALL be registered; latency is 1 clk from xpos/ypos to colour.
REQ-021 Position registers SHALL change only on frame_tick, so no tearing occurs within the visible area.
REQ-022 bx is 10 bits and by is 9 bits; arithmetic SHALL use 1-bit-wider signed intermediates so a step past 0 is detected as <= 0, not as a wrap to a large value.

Reset
REQ-023 On rst=1 at a clk edge:
- State = SERVE; bx = 316, by = 236, dx = dy = +1; py = 208.
- miss_count = 0; MISS counter = 0; previous-ypos register = 0.
- red/green/blue = 0.
REQ-024 rst mid-frame or mid-MISS SHALL take effect at that edge; the first frame_tick after reset is the next ypos transition to VACTIVE.

Verification
REQ-025 Reset then drive ypos 479->480: one frame_tick; btn_serve=0 -> ball stays at (316,236). Pixel (320,240) -> 7/7/3 one clk later; pixel (700,100) -> 0/0/0.
REQ-026 Serve, then 8 frames -> ball at (332,252). Force bx=630 (dx=+1), one frame -> bx=632, dx=-1. Force by=471 (dy=+1) -> by=472, dy=-1.
REQ-027 py=208, ball moving left with bx=25, by=230 -> next frame bx=25, dx=+1, no miss.
REQ-028 py=0, ball moving left with bx=2, by=300 -> bx=0, state MISS, miss_count=1. Background pixel = 4/0/0; SERVE is reached exactly 60 frame_ticks later.
REQ-029 btn_down held 110 frames -> py=416 (clamped). Both buttons -> py unchanged. btn_up held from py=2 -> py=0.
REQ-030 Force 16 misses -> miss_count=15 (saturated). Assert rst during MISS -> next clk: SERVE, miss_count=0, rgb=0.
